// File: rtl/ssd1306_vga_view.sv
// SSD1306 SPI sniffer: decodes OLED bus traffic into a page framebuffer
// and renders it scaled, centred and bordered on a parametrised VGA raster.
module ssd1306_vga_view #(
    parameter int          OLED_W   = 128,
    parameter int          OLED_H   = 64,
    parameter int          SCALE    = 4,
    parameter int          BORDER   = 10,
    parameter logic [3:0]  FG       = 4'hF,
    parameter logic [3:0]  BG       = 4'h0,
    parameter int          H_PULSE  = 96,
    parameter int          H_BP     = 48,
    parameter int          H_PIXELS = 640,
    parameter int          H_FP     = 16,
    parameter int          V_PULSE  = 2,
    parameter int          V_BP     = 31,
    parameter int          V_PIXELS = 480,
    parameter int          V_FP     = 11
) (
    input  logic       clk,
    input  logic       greset,
    input  logic       wclk,
    input  logic       din,
    input  logic       cs,
    input  logic       dc,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       frame_start
);
    localparam int PAGES    = OLED_H / 8;
    localparam int FB_DEPTH = OLED_W * PAGES;
    localparam int AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CW = (OLED_W > 1) ? $clog2(OLED_W) : 1;
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int H_FRAME = H_PULSE + H_BP + H_PIXELS + H_FP;
    localparam int V_FRAME = V_PULSE + V_BP + V_PIXELS + V_FP;
    localparam int HW = $clog2(H_FRAME);
    localparam int VW = $clog2(V_FRAME);
    localparam int H_OFF = H_PULSE + H_BP + (H_PIXELS - OLED_W * SCALE) / 2;
    localparam int V_OFF = V_PULSE + V_BP + (V_PIXELS - OLED_H * SCALE) / 2;
    localparam int H_END = H_OFF + OLED_W * SCALE;
    localparam int V_END = V_OFF + OLED_H * SCALE;

    localparam logic [HW-1:0] H_LAST = HW'(H_FRAME - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);
    localparam logic [HW-1:0] H_PRE  = HW'(H_OFF - 1);
    localparam logic [VW-1:0] V_PRE  = VW'(V_OFF - 1);
    localparam logic [HW-1:0] HX0 = HW'(H_OFF);
    localparam logic [HW-1:0] HX1 = HW'(H_END);
    localparam logic [VW-1:0] VY0 = VW'(V_OFF);
    localparam logic [VW-1:0] VY1 = VW'(V_END);
    localparam logic [HW-1:0] HB0 = HW'(H_OFF - BORDER);
    localparam logic [HW-1:0] HB1 = HW'(H_END + BORDER);
    localparam logic [VW-1:0] VB0 = VW'(V_OFF - BORDER);
    localparam logic [VW-1:0] VB1 = VW'(V_END + BORDER);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

    typedef enum logic [2:0] {IDLE, COL_A, COL_B, PAGE_A, PAGE_B} pstate_t;

    logic [2:0] wclk_s;
    logic [1:0] din_s, cs_s, dc_s;
    logic       rise;
    logic [2:0] bitcnt;
    logic [6:0] shreg;
    logic       bvalid, bdc;
    logic [7:0] bdata;

    always_ff @(posedge clk) begin
        if (greset) begin
            wclk_s <= '0;
            din_s  <= '0;
            cs_s   <= '1;
            dc_s   <= '0;
        end else begin
            wclk_s <= {wclk_s[1:0], wclk};
            din_s  <= {din_s[0], din};
            cs_s   <= {cs_s[0], cs};
            dc_s   <= {dc_s[0], dc};
        end
    end

    assign rise = wclk_s[1] & ~wclk_s[2];

    always_ff @(posedge clk) begin
        if (greset) begin
            bitcnt <= '0;
            shreg  <= '0;
            bvalid <= 1'b0;
            bdata  <= '0;
            bdc    <= 1'b0;
        end else begin
            bvalid <= 1'b0;
            if (cs_s[1]) begin
                bitcnt <= '0;
            end else if (rise) begin
                shreg  <= {shreg[5:0], din_s[1]};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    bvalid <= 1'b1;
                    bdata  <= {shreg, din_s[1]};
                    bdc    <= dc_s[1];
                end
            end
        end
    end

    pstate_t pstate, pnext;
    logic          disp_on, invert;
    logic [CW-1:0] col, col_start, col_end, byte_col;
    logic [PW-1:0] page, page_start, page_end, byte_page;

    assign byte_col  = CW'(32'(bdata) % OLED_W);
    assign byte_page = PW'(32'(bdata) % PAGES);

    always_ff @(posedge clk) begin
        if (greset) pstate <= IDLE;
        else        pstate <= pnext;
    end

    always_comb begin
        pnext = pstate;
        if (bvalid) begin
            if (bdc) begin
                pnext = IDLE;
            end else begin
                unique case (pstate)
                    IDLE: begin
                        if (bdata == 8'h21)      pnext = COL_A;
                        else if (bdata == 8'h22) pnext = PAGE_A;
                    end
                    COL_A:   pnext = COL_B;
                    PAGE_A:  pnext = PAGE_B;
                    default: pnext = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            disp_on    <= 1'b1;
            invert     <= 1'b0;
            col_start  <= '0;
            col_end    <= CW'(OLED_W - 1);
            page_start <= '0;
            page_end   <= PW'(PAGES - 1);
            col        <= '0;
            page       <= '0;
        end else if (bvalid && bdc) begin
            if (col == col_end) begin
                col  <= col_start;
                page <= (page == page_end) ? page_start : page + PW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else if (bvalid) begin
            unique case (pstate)
                IDLE: begin
                    if (bdata == 8'hAE) disp_on <= 1'b0;
                    if (bdata == 8'hAF) disp_on <= 1'b1;
                    if (bdata == 8'hA6) invert  <= 1'b0;
                    if (bdata == 8'hA7) invert  <= 1'b1;
                end
                COL_A: begin
                    col_start <= byte_col;
                    col       <= byte_col;
                end
                COL_B: col_end <= byte_col;
                PAGE_A: begin
                    page_start <= byte_page;
                    page       <= byte_page;
                end
                PAGE_B:  page_end <= byte_page;
                default: ;
            endcase
        end
    end

    logic [7:0]    fb [FB_DEPTH];
    logic [7:0]    rdata;
    logic [AW-1:0] waddr, raddr;

    assign waddr = AW'(32'(page) * OLED_W + 32'(col));

    always_ff @(posedge clk) begin
        if (bvalid && bdc) fb[waddr] <= bdata;
        rdata <= fb[raddr];
    end

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [15:0]   px, py;
    logic [SW-1:0] xsub, ysub;

    always_ff @(posedge clk) begin
        if (greset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // px/py track the panel coordinate of the current h/v without division
    always_ff @(posedge clk) begin
        if (greset) begin
            px   <= '0;
            xsub <= '0;
            py   <= '0;
            ysub <= '0;
        end else begin
            if (h == H_PRE) begin
                px   <= '0;
                xsub <= '0;
            end else if (xsub == S_LAST) begin
                px   <= px + 16'd1;
                xsub <= '0;
            end else begin
                xsub <= xsub + SW'(1);
            end
            if (h == H_LAST) begin
                if (v == V_PRE) begin
                    py   <= '0;
                    ysub <= '0;
                end else if (ysub == S_LAST) begin
                    py   <= py + 16'd1;
                    ysub <= '0;
                end else begin
                    ysub <= ysub + SW'(1);
                end
            end
        end
    end

    logic in_panel, in_band;
    logic p1_panel, p1_band, p1_hs, p1_vs, p1_fs;
    logic [2:0] p1_bit;
    logic [3:0] pix_col;

    assign in_panel = (h >= HX0) && (h < HX1) && (v >= VY0) && (v < VY1);
    assign in_band  = (h >= HB0) && (h < HB1) && (v >= VB0) && (v < VB1);
    assign raddr    = AW'(32'(py[15:3]) * OLED_W + 32'(px));

    always_ff @(posedge clk) begin
        if (greset) begin
            p1_panel <= 1'b0;
            p1_band  <= 1'b0;
            p1_bit   <= '0;
            p1_hs    <= 1'b0;
            p1_vs    <= 1'b0;
            p1_fs    <= 1'b0;
        end else begin
            p1_panel <= in_panel;
            p1_band  <= in_band;
            p1_bit   <= py[2:0];
            p1_hs    <= h >= HW'(H_PULSE);
            p1_vs    <= v >= VW'(V_PULSE);
            p1_fs    <= (h == '0) && (v == '0);
        end
    end

    always_comb begin
        pix_col = BG;
        if (p1_panel) begin
            if (disp_on && (rdata[p1_bit] ^ invert)) pix_col = FG;
        end else if (p1_band) begin
            pix_col = FG;
        end
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b0;
            vga_vsync   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= pix_col;
            vga_g       <= pix_col;
            vga_b       <= pix_col;
            vga_hsync   <= p1_hs;
            vga_vsync   <= p1_vs;
            frame_start <= p1_fs;
        end
    end

endmodule

// File: tb/tb_ssd1306_vga_view.sv
// Directed bench for ssd1306_vga_view on two compact raster geometries:
// a 16x16 panel at x2 and a 16x8 panel at x1.
module tb_ssd1306_vga_view;
    localparam int HFR = 2 + 2 + 40 + 2;
    localparam int VFR = 1 + 1 + 36 + 1;
    localparam int FR  = HFR * VFR;
    localparam logic [3:0] F = 4'hF;
    localparam logic [3:0] Z = 4'h0;

    logic clk = 1'b0;
    logic greset, wclk, din, cs, dc;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;

    int n_cmp = 0;
    int n_bad = 0;
    int pos_a = 32'h4000_0000;
    int pos_b = 32'h4000_0000;

    always #5 clk = ~clk;

    ssd1306_vga_view #(
        .OLED_W(16), .OLED_H(16), .SCALE(2), .BORDER(2),
        .FG(4'hF), .BG(4'h0),
        .H_PULSE(2), .H_BP(2), .H_PIXELS(40), .H_FP(2),
        .V_PULSE(1), .V_BP(1), .V_PIXELS(36), .V_FP(1)
    ) dut_a (
        .clk(clk), .greset(greset), .wclk(wclk), .din(din),
        .cs(cs), .dc(dc), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs)
    );

    ssd1306_vga_view #(
        .OLED_W(16), .OLED_H(8), .SCALE(1), .BORDER(1),
        .FG(4'hF), .BG(4'h0),
        .H_PULSE(2), .H_BP(2), .H_PIXELS(40), .H_FP(2),
        .V_PULSE(1), .V_BP(1), .V_PIXELS(36), .V_FP(1)
    ) dut_b (
        .clk(clk), .greset(greset), .wclk(wclk), .din(din),
        .cs(cs), .dc(dc), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs)
    );

    always @(negedge clk) begin
        pos_a <= a_fs ? 0 : pos_a + 1;
        pos_b <= b_fs ? 0 : pos_b + 1;
    end

    typedef struct {
        bit         send;
        bit         d;
        logic [7:0] b;
        int         inst;
        int         h;
        int         v;
        logic [3:0] e;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit s, input bit d, input logic [7:0] b,
                       input int inst, input int h, input int v,
                       input logic [3:0] e);
        vec_t t;
        t.send = s; t.d = d; t.b = b;
        t.inst = inst; t.h = h; t.v = v; t.e = e;
        tv.push_back(t);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic spi_bits(input logic d_c, input logic [7:0] b,
                            input int n);
        for (int i = 0; i < n; i++) begin
            dc   = d_c;
            din  = b[7-i];
            wclk = 1'b0;
            repeat (4) @(negedge clk);
            wclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        wclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_byte(input logic d_c, input logic [7:0] b);
        spi_bits(d_c, b, 8);
    endtask

    task automatic pix(input int inst, input int h, input int v,
                       input logic [3:0] e, input int id);
        int tgt;
        int k;
        int p;
        logic [11:0] got;
        tgt = v * HFR + h;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
            p = (inst == 0) ? pos_a : pos_b;
        end while (p != tgt && k < 3 * FR);
        got = (inst == 0) ? {a_r, a_g, a_b} : {b_r, b_g, b_b};
        n_cmp++;
        if (p != tgt || got !== {e, e, e}) begin
            n_bad++;
            $display("FAIL pix%0d inst%0d (%0d,%0d): got %h want %h",
                     id, inst, h, v, got, {e, e, e});
        end
    endtask

    function automatic logic sync_sel(input int s);
        return (s == 0) ? a_hs : a_vs;
    endfunction

    task automatic meas(input int s, output int low, output int per);
        int k;
        k = 0;
        while (sync_sel(s) !== 1'b1 && k < 3 * FR) begin
            @(negedge clk); k++;
        end
        while (sync_sel(s) !== 1'b0 && k < 3 * FR) begin
            @(negedge clk); k++;
        end
        low = 0;
        while (sync_sel(s) === 1'b0 && k < 3 * FR) begin
            @(negedge clk); k++; low++;
        end
        per = low;
        while (sync_sel(s) === 1'b1 && k < 3 * FR) begin
            @(negedge clk); k++; per++;
        end
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (a_fs !== 1'b1 && k < 3 * FR);
        chk("frame_start after reset", int'(a_fs), 1);
    endtask

    initial begin
        int lo, per;

        // A: panel h 8..39 v 4..35, band h 6..41 v 2..37
        add(0, 0, 8'h00, 0,  6,  4, F);
        add(0, 0, 8'h00, 0,  7, 10, F);
        add(0, 0, 8'h00, 0,  5, 10, Z);
        add(0, 0, 8'h00, 0, 20,  2, F);
        add(0, 0, 8'h00, 0, 20,  1, Z);
        add(0, 0, 8'h00, 0, 41, 10, F);
        add(0, 0, 8'h00, 0, 42, 10, Z);
        add(0, 0, 8'h00, 0, 20, 37, F);
        add(0, 0, 8'h00, 0, 20, 38, Z);
        add(0, 0, 8'h00, 0,  8,  4, Z);
        add(1, 1, 8'h01, 0,  8,  4, F);
        add(0, 0, 8'h00, 0,  9,  5, F);
        add(0, 0, 8'h00, 0, 10,  4, Z);
        add(0, 0, 8'h00, 0,  8,  6, Z);
        add(1, 0, 8'h21, 0, -1, -1, Z);
        add(1, 0, 8'h04, 0, -1, -1, Z);
        add(1, 0, 8'h05, 0, -1, -1, Z);
        add(1, 0, 8'h22, 0, -1, -1, Z);
        add(1, 0, 8'h01, 0, -1, -1, Z);
        add(1, 0, 8'h01, 0, -1, -1, Z);
        add(1, 1, 8'hFF, 0, -1, -1, Z);
        add(1, 1, 8'h80, 0, -1, -1, Z);
        add(1, 1, 8'h01, 0, 16, 20, F);
        add(0, 0, 8'h00, 0, 16, 22, Z);
        add(0, 0, 8'h00, 0, 18, 34, F);
        add(0, 0, 8'h00, 0, 18, 20, Z);
        add(0, 0, 8'h00, 0, 20, 20, Z);
        add(1, 0, 8'hA7, 0, 10,  4, F);
        add(0, 0, 8'h00, 0,  8,  4, Z);
        add(0, 0, 8'h00, 0, 20,  2, F);
        add(0, 0, 8'h00, 0,  5, 10, Z);
        add(1, 0, 8'hAE, 0, 20, 20, Z);
        add(0, 0, 8'h00, 0, 20,  2, F);
        add(1, 0, 8'hAF, 0, 10,  4, F);
        add(1, 0, 8'hA6, 0, 10,  4, Z);
        add(0, 0, 8'h00, 0,  8,  4, F);
        // B: panel h 16..31 v 16..23, band one pixel wide
        add(0, 0, 8'h00, 1, 15, 16, F);
        add(0, 0, 8'h00, 1, 14, 16, Z);
        add(0, 0, 8'h00, 1, 16, 15, F);
        add(0, 0, 8'h00, 1, 16, 14, Z);
        add(0, 0, 8'h00, 1, 32, 20, F);
        add(0, 0, 8'h00, 1, 33, 20, Z);
        add(0, 0, 8'h00, 1, 16, 16, F);
        add(0, 0, 8'h00, 1, 20, 16, F);
        add(0, 0, 8'h00, 1, 20, 17, Z);
        add(0, 0, 8'h00, 1, 21, 23, F);

        greset = 1'b1;
        cs = 1'b1; wclk = 1'b0; din = 1'b0; dc = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset A outputs", int'({a_r, a_g, a_b, a_hs, a_vs, a_fs}), 0);
        chk("reset B outputs", int'({b_r, b_g, b_b, b_hs, b_vs, b_fs}), 0);
        greset = 1'b0;

        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 32; i++) spi_byte(1'b1, 8'h00);

        meas(0, lo, per);
        chk("hsync low", lo, 2);
        chk("hsync period", per, HFR);
        meas(1, lo, per);
        chk("vsync low", lo, HFR);
        chk("vsync period", per, FR);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].send) spi_byte(tv[i].d, tv[i].b);
            if (tv[i].h >= 0)
                pix(tv[i].inst, tv[i].h, tv[i].v, tv[i].e, i);
        end

        // partial byte dropped by cs, then 0x40 lands at (page1,col5)
        spi_bits(1'b1, 8'hFF, 5);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(1'b1, 8'h40);
        pix(0, 18, 32, F, 100);
        pix(0, 18, 34, Z, 101);
        pix(0, 20, 32, Z, 102);
        pix(1, 21, 22, F, 103);
        pix(1, 21, 23, Z, 104);

        // reset while parser waits for an operand and mid-byte
        spi_byte(1'b0, 8'h21);
        spi_bits(1'b0, 8'hFF, 4);
        greset = 1'b1;
        repeat (3) @(negedge clk);
        greset = 1'b0;
        repeat (4) @(negedge clk);
        wait_fs();
        spi_byte(1'b0, 8'hA7);
        pix(0, 10, 4, F, 110);
        spi_byte(1'b1, 8'h02);
        pix(0, 8, 4, F, 111);
        pix(0, 8, 6, Z, 112);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
